// File: rtl/node_pkg.sv
// Shared types and constants for the 5-port router node switch allocator.
// Flit layout: [15] head, [14] tail, [13:11] dest port, [10:0] payload.
package node_pkg;
  localparam int DEF_NUM_PORTS = 5;
  localparam int FLIT_W        = 16;
  localparam int HEAD_BIT      = 15;
  localparam int TAIL_BIT      = 14;
  localparam int DEST_LSB      = 11;
  localparam int DEST_W        = 3;
  localparam int PAYLOAD_W     = 11;

  typedef logic [DEST_W-1:0] port_idx_t;

  typedef struct packed {
    logic                 head;
    logic                 tail;
    port_idx_t            dest;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  // Round-robin successor of port p in a ring of n ports.
  function automatic port_idx_t next_port(port_idx_t p, int n);
    if (int'(p) + 1 >= n) return '0;
    return port_idx_t'(p + 1'b1);
  endfunction
endpackage

// File: rtl/node_switch_alloc_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, cyclically.
// Zero latency; no backpressure of its own, the caller qualifies the grant.
module rr_arbiter
  import node_pkg::*;
#(
  parameter int N = DEF_NUM_PORTS
) (
  input  logic [N-1:0] req,
  input  port_idx_t    ptr,
  output logic [N-1:0] gnt,
  output logic         vld
);
  int idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = 0;
    for (int o = 0; o < N; o++) begin
      idx = (int'(ptr) + o) % N;
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/node_switch_alloc.sv
// Wormhole switch allocator: header at FIFO head in N -> grant end of N -> pop N+1 -> out_valid N+2.
// Pops stall on out_full (one-slot slack); optional counters under NODE_SWITCH_ALLOC_STATS_EN.
module node_switch_alloc
  import node_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               fifo_empty,
  input  logic [NUM_PORTS-1:0][FLIT_W-1:0]   fifo_head,
  output logic [NUM_PORTS-1:0]               fifo_pop,
  input  logic [NUM_PORTS-1:0]               out_full,
  output logic [NUM_PORTS-1:0]               out_valid,
  output logic [NUM_PORTS-1:0][FLIT_W-1:0]   out_data,
  output logic [7:0]                         drop_count
);
  logic [NUM_PORTS-1:0] locked;
  logic [NUM_PORTS-1:0] busy;
  port_idx_t            owner   [NUM_PORTS];
  port_idx_t            rr_ptr  [NUM_PORTS];

  logic [NUM_PORTS-1:0] drop;
  logic [NUM_PORTS-1:0] pop_busy;
  logic [NUM_PORTS-1:0] req     [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt     [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_vld;
  port_idx_t            gnt_idx [NUM_PORTS];

  // Drops are gated by rst so nothing leaves the FIFOs while reset is held.
  always_comb begin
    drop     = '0;
    pop_busy = '0;
    for (int j = 0; j < NUM_PORTS; j++) req[j] = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      drop[i] = rst && !fifo_empty[i] && !locked[i] &&
                (!fifo_head[i][HEAD_BIT] ||
                 int'(fifo_head[i][DEST_LSB +: DEST_W]) >= NUM_PORTS);
      for (int j = 0; j < NUM_PORTS; j++)
        req[j][i] = !fifo_empty[i] && !locked[i] && fifo_head[i][HEAD_BIT] &&
                    (int'(fifo_head[i][DEST_LSB +: DEST_W]) == j);
    end
    for (int j = 0; j < NUM_PORTS; j++)
      pop_busy[j] = busy[j] && !fifo_empty[owner[j]] && !out_full[j];
  end

  always_comb begin
    fifo_pop = drop;
    for (int j = 0; j < NUM_PORTS; j++)
      if (pop_busy[j]) fifo_pop[owner[j]] = 1'b1;
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .req (req[j]),
      .ptr (rr_ptr[j]),
      .gnt (gnt[j]),
      .vld (gnt_vld[j])
    );
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      gnt_idx[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        if (gnt[j][i]) gnt_idx[j] = port_idx_t'(i);
    end
  end

  // An input only ever requests its own header's dest, so grants on different
  // outputs always land on distinct inputs and never collide with a tail release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      locked    <= '0;
      out_valid <= '0;
      out_data  <= '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        owner[j]  <= '0;
        rr_ptr[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        out_valid[j] <= pop_busy[j];
        if (pop_busy[j]) out_data[j] <= fifo_head[owner[j]];
        if (busy[j]) begin
          if (pop_busy[j] && fifo_head[owner[j]][TAIL_BIT]) begin
            busy[j]          <= 1'b0;
            locked[owner[j]] <= 1'b0;
            rr_ptr[j]        <= next_port(owner[j], NUM_PORTS);
          end
        end else if (gnt_vld[j]) begin
          busy[j]            <= 1'b1;
          owner[j]           <= gnt_idx[j];
          locked[gnt_idx[j]] <= 1'b1;
        end
      end
    end
  end

`ifdef NODE_SWITCH_ALLOC_STATS_EN
  logic [15:0] flit_count [NUM_PORTS];
  logic [7:0]  drop_cnt_q;
  logic [8:0]  drop_sum;

  assign drop_sum   = {1'b0, drop_cnt_q} + 9'($countones(drop));
  assign drop_count = drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
      for (int j = 0; j < NUM_PORTS; j++) flit_count[j] <= '0;
    end else begin
      drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      for (int j = 0; j < NUM_PORTS; j++)
        if (pop_busy[j]) flit_count[j] <= flit_count[j] + 16'd1;
    end
  end
`else
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_node_switch_alloc.sv
// Randomized + directed bench for node_switch_alloc against a queue-based behavioural model.
module tb_node_switch_alloc;
  localparam int NP = 5;
`ifdef NODE_SWITCH_ALLOC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        fifo_empty, fifo_pop, out_full, out_valid;
  logic [NP-1:0][15:0]  fifo_head, out_data;
  logic [7:0]           drop_count;

  always #5 clk = ~clk;

  node_switch_alloc #(.NUM_PORTS(NP)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_head  (fifo_head),
    .fifo_pop   (fifo_pop),
    .out_full   (out_full),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .drop_count (drop_count)
  );

  // Input FIFO contents and per-output delivery logs
  logic [15:0] q    [NP][$];
  logic [15:0] olog [NP][$];

  // Behavioural model: owner of each output (-1 = idle), input locks, pointers
  int          own  [NP];
  bit          lockd[NP];
  int          rr   [NP];
  bit          ev   [NP];
  logic [15:0] ed   [NP];
  int          dcnt;
  bit          pend_pop [NP];

  bit          rst_req   = 1'b0;
  bit          rand_full = 1'b0;
  logic [NP-1:0] full_force = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(bit h, bit t, int d, int p);
    return {h, t, 3'(d), 11'(p)};
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NP; j++) begin
      own[j] = -1; lockd[j] = 1'b0; rr[j] = 0; ev[j] = 1'b0; ed[j] = '0;
    end
    dcnt = 0;
  endtask

  task automatic model_step();
    logic [NP-1:0] epop;
    logic [NP-1:0] evv;
    bit            dlv  [NP];
    logic [15:0]   dfl  [NP];
    int            gnt  [NP];
    int            ndrop;
    int            k;
    epop = '0; evv = '0; ndrop = 0;
    for (int j = 0; j < NP; j++) evv[j] = ev[j];
    if (!rst) begin
      chk("reset_pop", fifo_pop, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      chk("reset_drop_count", drop_count, 0);
      model_reset();
      return;
    end
    chk("out_valid", out_valid, evv);
    for (int j = 0; j < NP; j++) begin
      if (ev[j]) chk($sformatf("out_data[%0d]", j), out_data[j], ed[j]);
      if (out_valid[j]) olog[j].push_back(out_data[j]);
    end
    chk("drop_count", drop_count, STATS ? dcnt : 0);
    // what must leave the FIFOs this cycle
    for (int i = 0; i < NP; i++)
      if (q[i].size() > 0 && !lockd[i] && (!q[i][0][15] || q[i][0][13:11] >= NP)) begin
        epop[i] = 1'b1; ndrop++;
      end
    for (int j = 0; j < NP; j++) begin
      dlv[j] = 1'b0; dfl[j] = '0; gnt[j] = -1;
      if (own[j] >= 0) begin
        k = own[j];
        if (q[k].size() > 0 && !out_full[j]) begin
          dlv[j] = 1'b1; dfl[j] = q[k][0]; epop[k] = 1'b1;
        end
      end else begin
        for (int o = 0; o < NP; o++) begin
          k = (rr[j] + o) % NP;
          if (gnt[j] < 0 && q[k].size() > 0 && !lockd[k] && q[k][0][15] && q[k][0][13:11] == j)
            gnt[j] = k;
        end
      end
    end
    chk("fifo_pop", fifo_pop, epop);
    for (int j = 0; j < NP; j++) begin
      ev[j] = dlv[j];
      if (dlv[j]) begin
        ed[j] = dfl[j];
        if (dfl[j][14]) begin
          lockd[own[j]] = 1'b0; rr[j] = (own[j] + 1) % NP; own[j] = -1;
        end
      end
    end
    for (int j = 0; j < NP; j++)
      if (gnt[j] >= 0) begin own[j] = gnt[j]; lockd[gnt[j]] = 1'b1; end
    dcnt = (dcnt + ndrop > 255) ? 255 : dcnt + ndrop;
    for (int i = 0; i < NP; i++) pend_pop[i] = epop[i];
  endtask

  // Cycle process: drive inputs just after posedge, check against the model at negedge
  initial begin
    rst = 1'b1; fifo_empty = '1; fifo_head = '0; out_full = '0;
    for (int i = 0; i < NP; i++) pend_pop[i] = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) begin
        if (pend_pop[i] && q[i].size() > 0) void'(q[i].pop_front());
        pend_pop[i] = 1'b0;
      end
      rst = rst_req;
      for (int j = 0; j < NP; j++)
        out_full[j] = full_force[j] | (rand_full && ($urandom_range(3) == 0));
      for (int i = 0; i < NP; i++) begin
        fifo_empty[i] = (q[i].size() == 0);
        fifo_head[i]  = (q[i].size() == 0) ? 16'($urandom) : q[i][0];
      end
      @(negedge clk);
      model_step();
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clr_logs();
    for (int j = 0; j < NP; j++) olog[j].delete();
  endtask

  task automatic push_pkt(int i, int d, int len, int base);
    for (int n = 0; n < len; n++) q[i].push_back(mk(n == 0, n == len - 1, d, base + n));
  endtask

  initial begin
    logic [15:0] exp_l[$];
    int r, len;
    repeat (3) tick();
    rst_req = 1'b1;
    tick();

    // single-flit packet: grant, pop, deliver
    clr_logs();
    q[0].push_back(16'hC800);
    tick(); chk("t1_grant_cycle_pop", fifo_pop[0], 0);
    tick(); chk("t1_pop", fifo_pop[0], 1);
    tick(); chk("t1_valid", out_valid[1], 1); chk("t1_data", out_data[1], 16'hC800);
    tick(); chk("t1_valid_after", out_valid[1], 0);

    // three contenders for output 4, delivered whole in RR order 0,2,3
    clr_logs();
    push_pkt(0, 4, 3, 16'h000); push_pkt(2, 4, 3, 16'h020); push_pkt(3, 4, 3, 16'h030);
    repeat (15) tick();
    exp_l.delete();
    for (int n = 0; n < 3; n++) exp_l.push_back(mk(n == 0, n == 2, 4, 16'h000 + n));
    for (int n = 0; n < 3; n++) exp_l.push_back(mk(n == 0, n == 2, 4, 16'h020 + n));
    for (int n = 0; n < 3; n++) exp_l.push_back(mk(n == 0, n == 2, 4, 16'h030 + n));
    chk("t2_count", olog[4].size(), 9);
    for (int n = 0; n < 9 && n < olog[4].size(); n++) chk($sformatf("t2_flit%0d", n), olog[4][n], exp_l[n]);

    // backpressure mid-packet
    clr_logs();
    push_pkt(1, 2, 4, 16'h100);
    tick(); chk("t3_grant", fifo_pop[1], 0);
    tick(); chk("t3_pop0", fifo_pop[1], 1); full_force[2] = 1'b1;
    tick(); chk("t3_full_a", fifo_pop[1], 0);
    tick(); chk("t3_full_b", fifo_pop[1], 0);
    tick(); chk("t3_full_c", fifo_pop[1], 0); full_force[2] = 1'b0;
    tick(); chk("t3_resume", fifo_pop[1], 1);
    repeat (5) tick();
    chk("t3_count", olog[2].size(), 4);
    for (int n = 0; n < 4 && n < olog[2].size(); n++)
      chk($sformatf("t3_flit%0d", n), olog[2][n], mk(n == 0, n == 3, 2, 16'h100 + n));

    // bad dest header plus orphans
    clr_logs();
    q[0].push_back(mk(1, 0, 6, 16'h55)); q[0].push_back(mk(0, 0, 0, 16'h56)); q[0].push_back(mk(0, 1, 0, 16'h57));
    tick(); chk("t4_drop_pop", fifo_pop[0], 1);
    repeat (5) tick();
    chk("t4_drop_count", drop_count, STATS ? 3 : 0);
    chk("t4_no_output", olog[0].size() + olog[1].size() + olog[2].size() + olog[3].size() + olog[4].size(), 0);

    // two disjoint streams in parallel
    clr_logs();
    push_pkt(2, 0, 3, 16'h200); push_pkt(3, 1, 3, 16'h300);
    tick(); chk("t5_grant", fifo_pop[3:2], 2'b00);
    for (int n = 0; n < 3; n++) begin tick(); chk($sformatf("t5_pop%0d", n), fifo_pop[3:2], 2'b11); end
    repeat (4) tick();
    chk("t5_count0", olog[0].size(), 3); chk("t5_count1", olog[1].size(), 3);
    for (int n = 0; n < 3 && n < olog[0].size(); n++) chk($sformatf("t5_a%0d", n), olog[0][n], mk(n == 0, n == 2, 0, 16'h200 + n));
    for (int n = 0; n < 3 && n < olog[1].size(); n++) chk($sformatf("t5_b%0d", n), olog[1][n], mk(n == 0, n == 2, 1, 16'h300 + n));

    // reset after two flits of a five-flit packet
    clr_logs();
    push_pkt(4, 3, 5, 16'h400);
    tick(); tick(); tick(); rst_req = 1'b0;
    tick(); chk("t6_rst_valid", out_valid, 0); chk("t6_rst_pop", fifo_pop, 0); chk("t6_rst_data", out_data, 0);
    tick(); rst_req = 1'b1;
    repeat (8) tick();
    chk("t6_drop_count", drop_count, STATS ? 3 : 0);
    chk("t6_delivered", olog[3].size(), 1);

    // drop counter saturation, five orphans per cycle
    for (int i = 0; i < NP; i++) for (int n = 0; n < 52; n++) q[i].push_back(mk(0, 0, 0, i));
    repeat (60) tick();
    chk("sat_drop_count", drop_count, STATS ? 255 : 0);

    // random traffic with random backpressure and one mid-run reset
    rand_full = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c == 1500) rst_req = 1'b0;
      if (c == 1502) rst_req = 1'b1;
      for (int i = 0; i < NP; i++)
        if (q[i].size() < 3 && $urandom_range(2) == 0) begin
          r = $urandom_range(9);
          len = $urandom_range(1, 4);
          if (r == 0) q[i].push_back(mk(0, $urandom_range(1), $urandom_range(7), $urandom_range(2047)));
          else push_pkt(i, (r == 1) ? $urandom_range(5, 7) : $urandom_range(0, 4), len, $urandom_range(2047));
        end
    end
    rand_full = 1'b0;
    repeat (60) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
